// File: rtl/tpl_match_pkg.sv
// Shared definitions for the multi-template classifier: FSM encoding,
// score mid-point / saturation limits and the unsigned abs-difference helper.
package tpl_match_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DECIDE  = 2'd3
    } state_t;

    // Widest sample the abs-difference helper handles; narrower samples are zero-extended.
    localparam int MAX_DW  = 16;
    localparam int AGREE_W = 4;

    function automatic int score_mid(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int score_max(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic logic [MAX_DW:0] abs_diff(input logic [MAX_DW-1:0] a,
                                                 input logic [MAX_DW-1:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

endpackage

// File: rtl/multi_template_classifier_if.sv
// Sample/template input bundle and decision outputs of the classifier.
interface multi_template_classifier_if #(
    parameter int DW      = 8,
    parameter int NUM_TPL = 3,
    parameter int SCORE_W = 10
);
    localparam int TW = $clog2(NUM_TPL);

    logic                   frame_start;
    logic                   frame_end;
    logic                   sample_valid;
    logic [DW-1:0]          sample_in;
    logic [DW-1:0]          dsample_in;
    logic [NUM_TPL*DW-1:0]  tpl_in;
    logic [NUM_TPL*DW-1:0]  dtpl_in;
    logic [DW-1:0]          thr0;
    logic [DW-1:0]          thr1;
    logic                   busy;
    logic                   type_valid;
    logic [TW-1:0]          wave_type;
    logic [SCORE_W:0]       win_score;
    logic                   locked;

    modport master (
        output frame_start, frame_end, sample_valid, sample_in, dsample_in,
               tpl_in, dtpl_in, thr0, thr1,
        input  busy, type_valid, wave_type, win_score, locked
    );

    modport slave (
        input  frame_start, frame_end, sample_valid, sample_in, dsample_in,
               tpl_in, dtpl_in, thr0, thr1,
        output busy, type_valid, wave_type, win_score, locked
    );
endinterface

// File: rtl/tpl_score_acc.sv
// One saturating score accumulator: +1 on match, -2 on mismatch, clamped to [0, 2^SCORE_W-1].
module tpl_score_acc
    import tpl_match_pkg::*;
#(
    parameter int SCORE_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               en,
    input  logic               match,
    output logic [SCORE_W-1:0] score
);
    localparam logic [SCORE_W-1:0] MID = SCORE_W'(score_mid(SCORE_W));
    localparam logic [SCORE_W-1:0] MAX = SCORE_W'(score_max(SCORE_W));

    logic [SCORE_W-1:0] score_reg;
    logic [SCORE_W-1:0] score_next;
    logic [SCORE_W-1:0] base_val;

    // A sample arriving with clear counts as the first sample of the new frame.
    always_comb begin
        base_val   = clear ? MID : score_reg;
        score_next = base_val;
        if (en) begin
            if (match)
                score_next = (base_val == MAX) ? MAX : base_val + 1'b1;
            else
                score_next = (base_val < SCORE_W'(2)) ? '0 : base_val - SCORE_W'(2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            score_reg <= '0;
        else
            score_reg <= score_next;
    end

    assign score = score_reg;
endmodule

// File: rtl/multi_template_classifier.sv
// Frame-based template classifier with debounced type output.
// Define TPL_MATCH_DERIV_EN to add derivative scoring to every template total.
module multi_template_classifier
    import tpl_match_pkg::*;
#(
    parameter int DW      = 8,
    parameter int NUM_TPL = 3,
    parameter int SCORE_W = 10,
    parameter int AGREE_N = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multi_template_classifier_if.slave  bus
);
    localparam int TW = $clog2(NUM_TPL);

    state_t               state_reg, state_next;
    logic                 acc_clear, acc_en;
    logic                 sample_seen_reg;
    logic [TW-1:0]        scan_idx_reg;
    logic [TW-1:0]        best_idx_reg;
    logic [SCORE_W:0]     best_score_reg;
    logic [AGREE_W-1:0]   agree_cnt_reg, agree_next;
    logic [TW-1:0]        prev_win_reg;
    logic                 type_valid_reg;
    logic [TW-1:0]        wave_type_reg;
    logic [SCORE_W:0]     win_score_reg;
    logic                 locked_reg;
    logic [SCORE_W:0]     total [NUM_TPL];

    for (genvar gi = 0; gi < NUM_TPL; gi++) begin : g_tpl
        logic [MAX_DW:0]    diff0_full;
        logic               match0;
        logic [SCORE_W-1:0] score0;

        assign diff0_full = abs_diff(MAX_DW'(bus.sample_in), MAX_DW'(bus.tpl_in[gi*DW +: DW]));
        assign match0     = (diff0_full <= {1'b0, MAX_DW'(bus.thr0)});

        tpl_score_acc #(.SCORE_W(SCORE_W)) u_acc0 (
            .clk(clk), .rst_n(rst_n), .clear(acc_clear), .en(acc_en),
            .match(match0), .score(score0)
        );
`ifdef TPL_MATCH_DERIV_EN
        logic [MAX_DW:0]    diff1_full;
        logic               match1;
        logic [SCORE_W-1:0] score1;

        assign diff1_full = abs_diff(MAX_DW'(bus.dsample_in), MAX_DW'(bus.dtpl_in[gi*DW +: DW]));
        assign match1     = (diff1_full <= {1'b0, MAX_DW'(bus.thr1)});

        tpl_score_acc #(.SCORE_W(SCORE_W)) u_acc1 (
            .clk(clk), .rst_n(rst_n), .clear(acc_clear), .en(acc_en),
            .match(match1), .score(score1)
        );
        assign total[gi] = {1'b0, score0} + {1'b0, score1};
`else
        assign total[gi] = {1'b0, score0};
`endif
    end

`ifndef TPL_MATCH_DERIV_EN
    logic unused_deriv;
    assign unused_deriv = ^{bus.dsample_in, bus.dtpl_in, bus.thr1};
`endif

    // frame_end beats a simultaneous frame_start; an empty frame returns straight to IDLE.
    always_comb begin
        state_next = state_reg;
        acc_clear  = 1'b0;
        acc_en     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    state_next = ST_ACCUM;
                    acc_clear  = 1'b1;
                    acc_en     = bus.sample_valid;
                end
            end
            ST_ACCUM: begin
                acc_en = bus.sample_valid;
                if (bus.frame_end)
                    state_next = (sample_seen_reg || bus.sample_valid) ? ST_COMPARE : ST_IDLE;
                else if (bus.frame_start)
                    acc_clear = 1'b1;
            end
            ST_COMPARE: begin
                if (scan_idx_reg == TW'(NUM_TPL - 1))
                    state_next = ST_DECIDE;
            end
            ST_DECIDE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        if (agree_cnt_reg != '0 && best_idx_reg == prev_win_reg)
            agree_next = (agree_cnt_reg == '1) ? agree_cnt_reg : agree_cnt_reg + 1'b1;
        else
            agree_next = AGREE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            sample_seen_reg <= 1'b0;
            scan_idx_reg    <= '0;
            best_idx_reg    <= '0;
            best_score_reg  <= '0;
            agree_cnt_reg   <= '0;
            prev_win_reg    <= '0;
            type_valid_reg  <= 1'b0;
            wave_type_reg   <= '0;
            win_score_reg   <= '0;
            locked_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            type_valid_reg <= 1'b0;

            if (acc_clear)
                sample_seen_reg <= acc_en;
            else if (acc_en)
                sample_seen_reg <= 1'b1;

            if (state_reg == ST_ACCUM)
                scan_idx_reg <= '0;

            // Strict greater-than keeps the lower index on ties.
            if (state_reg == ST_COMPARE) begin
                if (scan_idx_reg == '0 || total[scan_idx_reg] > best_score_reg) begin
                    best_idx_reg   <= scan_idx_reg;
                    best_score_reg <= total[scan_idx_reg];
                end
                scan_idx_reg <= scan_idx_reg + 1'b1;
            end

            if (state_reg == ST_DECIDE) begin
                agree_cnt_reg  <= agree_next;
                prev_win_reg   <= best_idx_reg;
                type_valid_reg <= 1'b1;
                win_score_reg  <= best_score_reg;
                if (agree_next >= AGREE_W'(AGREE_N)) begin
                    wave_type_reg <= best_idx_reg;
                    locked_reg    <= 1'b1;
                end
            end
        end
    end

    assign bus.busy       = (state_reg == ST_COMPARE) || (state_reg == ST_DECIDE);
    assign bus.type_valid = type_valid_reg;
    assign bus.wave_type  = wave_type_reg;
    assign bus.win_score  = win_score_reg;
    assign bus.locked     = locked_reg;
endmodule

// File: tb/tb_multi_template_classifier.sv
// Scoreboard bench for multi_template_classifier: a behavioural model predicts each
// frame decision at frame_end and the monitor compares it against every type_valid pulse.
module tb_multi_template_classifier;
    localparam int DW      = 8;
    localparam int NUM_TPL = 3;
    localparam int SCORE_W = 10;
    localparam int AGREE_N = 2;
    localparam int SMID    = 1 << (SCORE_W - 1);
    localparam int SMAX    = (1 << SCORE_W) - 1;
`ifdef TPL_MATCH_DERIV_EN
    localparam bit DERIV = 1'b1;
`else
    localparam bit DERIV = 1'b0;
`endif

    typedef struct {
        int wtype;
        int score;
        int locked;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_template_classifier_if #(.DW(DW), .NUM_TPL(NUM_TPL), .SCORE_W(SCORE_W)) bus ();

    multi_template_classifier #(
        .DW(DW), .NUM_TPL(NUM_TPL), .SCORE_W(SCORE_W), .AGREE_N(AGREE_N)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_total = 0;
    int n_bad = 0;
    int cyc = 0;
    int fe_edge = 0;
    int pulse_cnt = 0;
    int last_score = 0;
    exp_t exp_q[$];

    logic [DW-1:0] tpl_v  [NUM_TPL];
    logic [DW-1:0] dtpl_v [NUM_TPL];
    logic [DW-1:0] s_fix = 8'd150;
    logic [DW-1:0] ds_fix = 8'd128;

    // model state
    int m_s0[NUM_TPL];
    int m_s1[NUM_TPL];
    int m_count = 0;
    bit m_accum = 1'b0;
    int m_busy_left = 0;
    int m_agree = 0;
    int m_prev = 0;
    int m_type = 0;
    int m_locked = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat_step(input int sc, input bit hit);
        if (hit) return (sc + 1 > SMAX) ? SMAX : sc + 1;
        return (sc < 2) ? 0 : sc - 2;
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < NUM_TPL; k++) begin
            m_s0[k] = SMID;
            m_s1[k] = SMID;
        end
        m_count = 0;
    endtask

    task automatic m_apply(input logic [DW-1:0] s, input logic [DW-1:0] ds);
        for (int k = 0; k < NUM_TPL; k++) begin
            m_s0[k] = sat_step(m_s0[k], absd(int'(s), int'(tpl_v[k])) <= int'(bus.thr0));
            m_s1[k] = sat_step(m_s1[k], absd(int'(ds), int'(dtpl_v[k])) <= int'(bus.thr1));
        end
        m_count++;
    endtask

    task automatic m_decide();
        int best;
        int w;
        int t;
        best = -1;
        w = 0;
        for (int k = 0; k < NUM_TPL; k++) begin
            t = m_s0[k] + (DERIV ? m_s1[k] : 0);
            if (t > best) begin
                best = t;
                w = k;
            end
        end
        if (m_agree != 0 && w == m_prev) m_agree = (m_agree < 15) ? m_agree + 1 : 15;
        else m_agree = 1;
        m_prev = w;
        if (m_agree >= AGREE_N) begin
            m_type = w;
            m_locked = 1;
        end
        exp_q.push_back('{wtype: m_type, score: best, locked: m_locked});
    endtask

    // One clock of stimulus; the model follows the same acceptance rules as the frame protocol.
    task automatic drive(input bit fs, input bit fe, input bit sv,
                         input logic [DW-1:0] s, input logic [DW-1:0] ds);
        @(negedge clk);
        bus.frame_start  = fs;
        bus.frame_end    = fe;
        bus.sample_valid = sv;
        bus.sample_in    = s;
        bus.dsample_in   = ds;
        for (int k = 0; k < NUM_TPL; k++) begin
            bus.tpl_in[k*DW +: DW]  = tpl_v[k];
            bus.dtpl_in[k*DW +: DW] = dtpl_v[k];
        end
        if (m_busy_left > 0) begin
            m_busy_left--;
        end else if (!m_accum) begin
            if (fs) begin
                m_clear();
                m_accum = 1'b1;
                if (sv) m_apply(s, ds);
            end
        end else if (fe) begin
            if (sv) m_apply(s, ds);
            m_accum = 1'b0;
            if (m_count > 0) begin
                m_decide();
                m_busy_left = NUM_TPL + 1;
                fe_edge = cyc + 1;
            end
        end else begin
            if (fs) m_clear();
            if (sv) m_apply(s, ds);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic pick(input bit rnd, output logic [DW-1:0] s, output logic [DW-1:0] ds);
        if (rnd) begin
            s  = DW'($urandom_range(90, 210));
            ds = DW'($urandom_range(90, 210));
        end else begin
            s  = s_fix;
            ds = ds_fix;
        end
    endtask

    task automatic wait_results();
        for (int i = 0; i < NUM_TPL + 20 && exp_q.size() != 0; i++) idle(1);
        check("result_wait", exp_q.size(), 0);
        exp_q.delete();
        idle(2);
    endtask

    task automatic run_frame(input int n, input bit rnd, input bit edge_s,
                             input int restart_at, input bit close_both);
        logic [DW-1:0] s, ds;
        pick(rnd, s, ds);
        drive(1'b1, 1'b0, edge_s, s, ds);
        for (int i = 0; i < n; i++) begin
            pick(rnd, s, ds);
            drive(i == restart_at, 1'b0, rnd ? ($urandom_range(0, 3) != 0) : 1'b1, s, ds);
        end
        pick(rnd, s, ds);
        drive(close_both, 1'b1, edge_s, s, ds);
        wait_results();
    endtask

    // Template k matches when k == w; others sit 50+ codes away in both halves.
    task automatic set_tpls(input int w);
        for (int k = 0; k < NUM_TPL; k++) begin
            tpl_v[k]  = (k == w) ? 8'd150 : ((k < w) ? 8'd100 : 8'd200);
            dtpl_v[k] = (k == w) ? 8'd128 : ((k < w) ? 8'd60 : 8'd200);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.frame_start  = 1'b0;
        bus.frame_end    = 1'b0;
        bus.sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_type_valid", bus.type_valid, 0);
        check("rst_wave_type", bus.wave_type, 0);
        check("rst_win_score", bus.win_score, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_locked", bus.locked, 0);
        rst_n = 1'b1;
        m_accum = 1'b0;
        m_busy_left = 0;
        m_agree = 0;
        m_prev = 0;
        m_type = 0;
        m_locked = 0;
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.type_valid) begin
            pulse_cnt++;
            last_score = int'(bus.win_score);
            $display("result %0d: wave_type=%0d win_score=%0d locked=%0d at cycle %0d",
                     pulse_cnt, bus.wave_type, bus.win_score, bus.locked, cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wave_type", int'(bus.wave_type), e.wtype);
                check("win_score", int'(bus.win_score), e.score);
                check("locked", int'(bus.locked), e.locked);
                check("busy_fall", int'(bus.busy), 0);
                check("latency", cyc - fe_edge, NUM_TPL + 1);
            end
        end
    end

    initial begin
        int p0;
        bus.frame_start = 1'b0;
        bus.frame_end = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_in = '0;
        bus.dsample_in = '0;
        bus.tpl_in = '0;
        bus.dtpl_in = '0;
        bus.thr0 = 8'd7;
        bus.thr1 = 8'd7;
        set_tpls(1);
        do_reset();

        // exact match on template 1
        set_tpls(1);
        run_frame(62, 1'b0, 1'b1, -1, 1'b0);
        check("exact_score", last_score, DERIV ? 1152 : 576);

        // debounce: winners 1, 2, 2
        do_reset();
        p0 = pulse_cnt;
        set_tpls(1);
        run_frame(20, 1'b0, 1'b0, -1, 1'b0);
        check("deb1_type", int'(bus.wave_type), 0);
        check("deb1_locked", int'(bus.locked), 0);
        set_tpls(2);
        run_frame(20, 1'b0, 1'b0, -1, 1'b0);
        check("deb2_type", int'(bus.wave_type), 0);
        check("deb2_locked", int'(bus.locked), 0);
        run_frame(20, 1'b0, 1'b0, -1, 1'b0);
        check("deb3_type", int'(bus.wave_type), 2);
        check("deb3_locked", int'(bus.locked), 1);
        check("deb_pulses", pulse_cnt - p0, 3);

        // tie between templates 0 and 2, twice to confirm winner 0
        set_tpls(0);
        tpl_v[2] = 8'd150;
        dtpl_v[2] = 8'd128;
        run_frame(32, 1'b0, 1'b0, -1, 1'b0);
        run_frame(32, 1'b0, 1'b0, -1, 1'b0);
        check("tie_type", int'(bus.wave_type), 0);

        // saturation low and high
        set_tpls(-1);
        run_frame(300, 1'b0, 1'b0, -1, 1'b0);
        check("sat_low_score", last_score, 0);
        set_tpls(2);
        run_frame(600, 1'b0, 1'b0, -1, 1'b0);
        check("sat_high_score", last_score, DERIV ? 2 * SMAX : SMAX);

        // random frames: edge samples, mid-frame restart, start+end together
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < NUM_TPL; k++) begin
                tpl_v[k]  = DW'($urandom_range(90, 210));
                dtpl_v[k] = DW'($urandom_range(90, 210));
            end
            bus.thr0 = DW'($urandom_range(0, 40));
            bus.thr1 = DW'($urandom_range(0, 40));
            run_frame(30 + f * 10, 1'b1, (f % 2) == 1, (f == 2) ? 12 : -1, f == 3);
        end
        bus.thr0 = 8'd7;
        bus.thr1 = 8'd7;

        // empty frame
        p0 = pulse_cnt;
        drive(1'b1, 1'b0, 1'b0, s_fix, ds_fix);
        drive(1'b0, 1'b1, 1'b0, s_fix, ds_fix);
        idle(NUM_TPL + 6);
        check("empty_pulses", pulse_cnt - p0, 0);
        check("empty_busy", int'(bus.busy), 0);

        // frame_start while busy is ignored
        set_tpls(1);
        drive(1'b1, 1'b0, 1'b1, s_fix, ds_fix);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b1, s_fix, ds_fix);
        drive(1'b0, 1'b1, 1'b0, s_fix, ds_fix);
        drive(1'b1, 1'b0, 1'b1, s_fix, ds_fix);
        check("busy_high", int'(bus.busy), 1);
        drive(1'b0, 1'b0, 1'b1, s_fix, ds_fix);
        wait_results();
        p0 = pulse_cnt;
        drive(1'b0, 1'b1, 1'b1, s_fix, ds_fix);
        idle(NUM_TPL + 6);
        check("post_busy_pulses", pulse_cnt - p0, 0);

        // reset in the middle of ACCUM
        drive(1'b1, 1'b0, 1'b1, s_fix, ds_fix);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, s_fix, ds_fix);
        do_reset();
        p0 = pulse_cnt;
        drive(1'b0, 1'b1, 1'b1, s_fix, ds_fix);
        idle(NUM_TPL + 6);
        check("rst_discard_pulses", pulse_cnt - p0, 0);
        run_frame(62, 1'b0, 1'b1, -1, 1'b0);
        check("post_rst_score", last_score, DERIV ? 1152 : 576);

        idle(4);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/multi_template_classifier.md
# multi_template_classifier

Frame-based waveform classifier for the oscilloscope AI-match path. It scores each incoming sample, and optionally its derivative, against NUM_TPL parallel reference templates, and accumulates saturating per-template scores over one frame. At frame end it selects the best template and publishes a debounced type code. It sits between the sample/derivative front end and the display/measurement logic, and is the parametrised next generation of the three-template matcher.

## Interface
- DW, 8: sample, derivative and template width (unsigned, mid-scale = 2^(DW-1))
- NUM_TPL, 3: number of templates (2..8)
- SCORE_W, 10: per-template score accumulator width
- AGREE_N, 2: consecutive identical frame winners required before wave_type changes (1..15)
- TW = clog2(NUM_TPL): type code width (localparam)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- frame_start  in  1  pulse: clear scores, begin frame
- frame_end  in  1  pulse: close frame, start decision
- sample_valid  in  1  sample_in/dsample_in/templates valid this cycle
- sample_in  in  DW  raw sample
- dsample_in  in  DW  derivative sample, offset-binary
- tpl_in  in  NUM_TPL*DW  template values, template k at [k*DW +: DW]
- dtpl_in  in  NUM_TPL*DW  derivative template values, same packing
- thr0  in  DW  raw match threshold (runtime)
- thr1  in  DW  derivative match threshold (runtime)
- busy  out  1  high in COMPARE/DECIDE; inputs ignored
- type_valid  out  1  one-cycle pulse per decided frame
- wave_type  out  TW  debounced winning template index
- win_score  out  SCORE_W+1  total score of this frame's winner
- locked  out  1  wave_type has been confirmed at least once since reset

## Operation
- FSM: IDLE, ACCUM, COMPARE, DECIDE.
  - IDLE: on frame_start, go to ACCUM.
  - ACCUM: on frame_end, go to COMPARE.
  - COMPARE: after NUM_TPL cycles, go to DECIDE.
  - DECIDE: after 1 cycle, go to IDLE.
- frame_start loads every score with 2^(SCORE_W-1) and clears the frame sample counter.
  - A frame_start seen in ACCUM restarts the frame.
  - A frame_start seen in COMPARE/DECIDE is ignored.
- Per valid sample, per template k:
  - Compute diff = |sample_in - tpl_k| in DW+1 bits, with no wrap-around.
  - If diff <= thr0, add 1 to score0_k; otherwise subtract 2.
  - Derivative score1_k is updated the same way using dsample_in, dtpl_k and thr1.
- Scores saturate: clamp at 0 on underflow and at 2^SCORE_W-1 on overflow.
- total_k = score0_k + score1_k, in SCORE_W+1 bits.
- COMPARE scans k = 0..NUM_TPL-1 at one per cycle, keeping the running maximum. Ties go to the lower index.
- DECIDE:
  - If the winner equals the previous frame's winner, increment the agree counter (saturating); otherwise set the counter to 1.
  - When the counter reaches AGREE_N: wave_type <= winner and locked <= 1.
  - type_valid pulses and win_score is updated.
- Empty frame (frame_end with zero valid samples): go straight to IDLE, with no pulse and no change to outputs or the agree counter.

## Timing
- Reset values: type_valid 0, wave_type 0, win_score 0, busy 0, locked 0, agree counter 0, FSM IDLE.
- Reset mid-frame discards all scores.
- A score update is visible 1 cycle after sample_valid.
- frame_start together with sample_valid: the sample counts as the first sample of the new frame.
- frame_end together with sample_valid: the sample counts, then the frame closes.
- frame_start and frame_end in the same cycle while in ACCUM: frame_end wins and frame_start is ignored.
- busy rises the cycle after frame_end. type_valid pulses NUM_TPL+1 cycles after frame_end, and busy falls with it.
- wave_type and win_score change only in the type_valid cycle.

## Configuration
- TPL_MATCH_DERIV_EN defined: derivative scoring is active as described above.
- Undefined: score1 logic is removed and total_k = score0_k, zero-extended. The dsample_in, dtpl_in and thr1 ports remain but are ignored.

## Structure
- Shared package/header tpl_match_pkg holds:
  - the FSM state encodings;
  - the score mid-point and saturation-limit constants;
  - the abs-difference helper function.
- Sub-module tpl_score_acc holds one saturating accumulator: inputs clear, en, match; output score. It is instantiated NUM_TPL times, or 2*NUM_TPL times with TPL_MATCH_DERIV_EN.

## Test plan
Common setup: NUM_TPL=3, SCORE_W=10, thr0=7, derivative enabled unless noted.
- Exact match: 64 samples with sample_in = tpl1, tpl0/tpl2 offset by 50, dsample_in = dtpl1 -> winner 1, win_score 1152; the others score 384 each in the raw half.
- Tie: tpl0 = tpl2 = sample_in and dtpl0 = dtpl2 = dsample_in for 32 samples -> winner 0.
- Saturation:
  - 300 mismatching samples -> score 0, with no wrap to high values.
  - 600 matching samples -> score clamped at 1023.
- Debounce with AGREE_N=2: frame winners 1, 2, 2 -> wave_type stays 0, stays 0, then becomes 2; locked rises on the third frame; type_valid pulses 3 times.
- Boundaries:
  - frame_end with no samples -> no type_valid.
  - frame_start during busy -> ignored.
  - rst_n low mid-ACCUM -> all outputs at reset values.
- Derivative disabled (TPL_MATCH_DERIV_EN undefined): same stimulus as Exact match -> win_score 576.
